pc_unit: RTL and testbench

- Parametrised program-counter unit for the CPU fetch stage; next generation of the plain PC register.
- Adds configurable address width, sequential step, relative branch, absolute jump, trap vector and stall.
- Includes a hardware return-address stack (RAS) for CALL/RET.
- Drives the instruction-memory address; takes control from the decode/branch logic.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/pc_ras.sv | 52 +++++
 rtl/pc_unit.sv | 95 +++++++++
 tb/tb_pc_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Op encodings and default widths.
package cpu_pkg;
  localparam int OP_W       = 3;
  localparam int ADDR_W_DEF = 8;

  localparam logic [OP_W-1:0] OP_SEQ  = 3'd0;
  localparam logic [OP_W-1:0] OP_BR   = 3'd1;
  localparam logic [OP_W-1:0] OP_JMP  = 3'd2;
  localparam logic [OP_W-1:0] OP_CALL = 3'd3;
  localparam logic [OP_W-1:0] OP_RET  = 3'd4;
endpackage

// File: rtl/pc_ras.sv
// Return-address stack.
// Circular LIFO; a push while full overwrites the oldest entry.
module pc_ras
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              ovf
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW:0]       r_cnt;
  logic [PW-1:0]     w_rp;

  assign w_rp  = r_wp - PW'(1);
  assign dout  = r_mem[w_rp];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == (PW+1)'(RAS_DEPTH));
  assign ovf   = push && full;

  // Write pointer and occupancy; count saturates when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_wp <= r_wp + PW'(1);
      if (!full)
        r_cnt <= r_cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      r_wp  <= w_rp;
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  // Entry storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push)
      r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter.
// Next-PC select, PC register, return stack and error pulses.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                STEP       = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR  = ADDR_W'(8'hF0),
  parameter int                RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              trap,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] tgt,
  input  logic [ADDR_W-1:0] off,
  output logic [ADDR_W-1:0] pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              err_ovf,
  output logic              err_unf
);
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_ras_dout;
  logic              w_act;
  logic              w_call;
  logic              w_ret;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_ovf;
  logic              r_ovf;
  logic              r_unf;

  assign w_pc_inc = r_pc + ADDR_W'(STEP);
  assign w_act    = !trap && en;
  assign w_call   = w_act && (op == OP_CALL);
  assign w_ret    = w_act && (op == OP_RET);
  assign w_pop    = w_ret && !w_empty;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (w_call),
    .pop   (w_pop),
    .din   (w_pc_inc),
    .dout  (w_ras_dout),
    .empty (w_empty),
    .full  (w_full),
    .ovf   (w_ovf)
  );

  // Next-PC select: trap beats stall beats op.
  always_comb begin
    w_pc_nxt = r_pc;
    if (trap) begin
      w_pc_nxt = TRAP_ADDR;
    end else if (en) begin
      unique case (op)
        OP_SEQ:  w_pc_nxt = w_pc_inc;
        OP_BR:   w_pc_nxt = r_pc + off;
        OP_JMP:  w_pc_nxt = tgt;
        OP_CALL: w_pc_nxt = tgt;
        OP_RET:  w_pc_nxt = w_empty ? w_pc_inc : w_ras_dout;
        default: w_pc_nxt = r_pc;
      endcase
    end
  end

  // PC register and single-cycle error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_ADDR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_ovf <= w_ovf;
      r_unf <= w_ret && w_empty;
    end
  end

  assign pc        = r_pc;
  assign ras_empty = w_empty;
  assign ras_full  = w_full;
  assign err_ovf   = r_ovf;
  assign err_unf   = r_unf;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit.
// Reference model feeds an expectation queue checked after each edge.
module tb_pc_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [7:0] pc;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       trap = 1'b0;
  logic [2:0] op = 3'd5;
  logic [7:0] tgt = '0;
  logic [7:0] off = '0;
  logic [7:0] pc;
  logic       ras_empty, ras_full, err_ovf, err_unf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  exp_t       sb[$];

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_W     (8),
    .STEP       (1),
    .RESET_ADDR (8'h00),
    .TRAP_ADDR  (8'hF0),
    .RAS_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .trap      (trap),
    .op        (op),
    .tgt       (tgt),
    .off       (off),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic e,
                      input logic [2:0] o, input logic [7:0] tg,
                      input logic [7:0] of);
    exp_t x;
    logic mo, mu;
    rst = r; trap = t; en = e; op = o; tgt = tg; off = of;
    mo = 1'b0;
    mu = 1'b0;
    if (r) begin
      m_pc = 8'h00;
      m_stk.delete();
    end else if (t) begin
      m_pc = 8'hF0;
    end else if (e) begin
      case (o)
        3'd0: m_pc = m_pc + 8'd1;
        3'd1: m_pc = m_pc + of;
        3'd2: m_pc = tg;
        3'd3: begin
          if (m_stk.size() == 4) begin
            void'(m_stk.pop_front());
            mo = 1'b1;
          end
          m_stk.push_back(m_pc + 8'd1);
          m_pc = tg;
        end
        3'd4: begin
          if (m_stk.size() > 0) m_pc = m_stk.pop_back();
          else begin
            m_pc = m_pc + 8'd1;
            mu = 1'b1;
          end
        end
        default: ;
      endcase
    end
    x.pc  = m_pc;
    x.emp = (m_stk.size() == 0);
    x.ful = (m_stk.size() == 4);
    x.ovf = mo;
    x.unf = mu;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("pc", 32'(pc), 32'(x.pc));
    chk("ras_empty", 32'(ras_empty), 32'(x.emp));
    chk("ras_full", 32'(ras_full), 32'(x.ful));
    chk("err_ovf", 32'(err_ovf), 32'(x.ovf));
    chk("err_unf", 32'(err_unf), 32'(x.unf));
  endtask

  task automatic run(input logic [2:0] o, input logic [7:0] tg,
                     input logic [7:0] of);
    step(1'b0, 1'b0, 1'b1, o, tg, of);
  endtask

  initial begin
    m_pc = 8'h00;
    // 1: reset and sequential
    step(1'b1, 1'b0, 1'b0, OP_SEQ, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b1, OP_SEQ, 8'h00, 8'h00);
    chk("t1_rst_pc", 32'(pc), 32'h00);
    for (int i = 0; i < 5; i++) run(OP_SEQ, 8'h00, 8'h00);
    chk("t1_seq_pc", 32'(pc), 32'h05);
    // 2: wrap and negative branch
    run(OP_JMP, 8'hFE, 8'h00);
    run(OP_SEQ, 8'h00, 8'h00);
    run(OP_SEQ, 8'h00, 8'h00);
    chk("t2_wrap", 32'(pc), 32'h00);
    run(OP_BR, 8'h00, 8'hFC);
    chk("t2_br", 32'(pc), 32'hFC);
    // 3: call/return
    run(OP_JMP, 8'h10, 8'h00);
    run(OP_CALL, 8'h40, 8'h00);
    run(OP_CALL, 8'h80, 8'h00);
    chk("t3_call", 32'(pc), 32'h80);
    run(OP_RET, 8'h00, 8'h00);
    chk("t3_ret1", 32'(pc), 32'h41);
    run(OP_RET, 8'h00, 8'h00);
    chk("t3_ret2", 32'(pc), 32'h11);
    chk("t3_empty", 32'(ras_empty), 32'h1);
    // 4: overflow then underflow
    run(OP_JMP, 8'h00, 8'h00);
    for (int i = 1; i <= 5; i++) run(OP_CALL, 8'(i * 16), 8'h00);
    chk("t4_full", 32'(ras_full), 32'h1);
    chk("t4_ovf", 32'(err_ovf), 32'h1);
    for (int i = 0; i < 4; i++) run(OP_RET, 8'h00, 8'h00);
    chk("t4_ret4", 32'(pc), 32'h11);
    run(OP_RET, 8'h00, 8'h00);
    chk("t4_unf", 32'(err_unf), 32'h1);
    chk("t4_unf_pc", 32'(pc), 32'h12);
    // 5: stall and trap priority
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, OP_JMP, 8'h33, 8'h00);
    chk("t5_stall", 32'(pc), 32'h12);
    step(1'b0, 1'b1, 1'b0, OP_JMP, 8'h33, 8'h00);
    chk("t5_trap", 32'(pc), 32'hF0);
    run(OP_CALL, 8'h20, 8'h00);
    step(1'b0, 1'b1, 1'b1, OP_CALL, 8'h60, 8'h00);
    run(OP_RET, 8'h00, 8'h00);
    chk("t5_ret", 32'(pc), 32'hF1);
    chk("t5_empty", 32'(ras_empty), 32'h1);
    // 6: reset with stacked entries
    for (int i = 0; i < 3; i++) run(OP_CALL, 8'(8'h30 + i), 8'h00);
    step(1'b1, 1'b0, 1'b1, OP_RET, 8'h00, 8'h00);
    chk("t6_rst_pc", 32'(pc), 32'h00);
    chk("t6_rst_emp", 32'(ras_empty), 32'h1);
    run(OP_RET, 8'h00, 8'h00);
    chk("t6_unf", 32'(err_unf), 32'h1);
    // random mix against the model
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
           8'($urandom), 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
